// File: rtl/db_multi_if.sv
// Raw-input / debounced-output bundle for db_multi.
// The slave side is the debouncer, the master side drives the raw inputs.
interface db_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] raw_input;
  logic [CHANNELS-1:0] db;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic                any_change;
  logic                tick;

  modport master (
    output raw_input,
    input  db,
    input  rise,
    input  fall,
    input  any_change,
    input  tick
  );

  modport slave (
    input  raw_input,
    output db,
    output rise,
    output fall,
    output any_change,
    output tick
  );
endinterface

// File: rtl/db_multi.sv
// Multi-channel debouncer: 2-flop sync, shared tick enable,
// per-channel stable-for-N-ticks filter with rise/fall pulses.
module db_multi #(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 3
) (
  input  logic         clk,
  input  logic         rst,
  db_multi_if.slave    bus
);

  localparam int PW = (TICK_DIV > 1) ?
                      $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 1) ?
                      $clog2(STABLE_TICKS) : 1;
  localparam logic [PW-1:0] P_LAST =
    PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_LAST =
    CW'(STABLE_TICKS - 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [PW-1:0]       presc;
  logic                tick;
  logic [CW-1:0]       cnt [CHANNELS];
  logic [CHANNELS-1:0] db_q;
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;

  assign tick = (presc == P_LAST);

  // Two-stage synchroniser for the asynchronous inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.raw_input;
      sync2 <= sync1;
    end
  end

  // Prescaler producing the shared sample-tick enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Per-channel filter: a new level must survive STABLE_TICKS ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync2[i] == db_q[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == C_LAST) begin
            db_q[i]   <= sync2[i];
            rise_q[i] <= sync2[i];
            fall_q[i] <= ~sync2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign bus.db         = db_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.any_change = |(rise_q | fall_q);
  assign bus.tick       = tick;

endmodule

// File: tb/tb_db_multi.sv
// Bench for db_multi: directed scenarios plus random bouncing,
// checked every cycle against a cycle-index based reference model.
module tb_db_multi;

  localparam int CH = 4;
  localparam int TD = 4;
  localparam int ST = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests = 0;
  int fails = 0;

  db_multi_if #(.CHANNELS(CH)) bus ();

  db_multi #(
    .CHANNELS    (CH),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: cycle index since reset, raw history,
  // and the first cycle of each channel's current mismatch run.
  int          m_cyc = 0;
  logic [CH-1:0] p1 = '0;
  logic [CH-1:0] p2 = '0;
  logic [CH-1:0] m_db = '0;
  logic [CH-1:0] m_rise = '0;
  logic [CH-1:0] m_fall = '0;
  int          run [CH];

  function automatic int nticks(int a, int b);
    return (b + 1) / TD - a / TD;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cyc  = 0;
      p1     = '0;
      p2     = '0;
      m_db   = '0;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < CH; i++) run[i] = -1;
    end else begin
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < CH; i++) begin
        if (p2[i] == m_db[i]) begin
          run[i] = -1;
        end else begin
          if (run[i] < 0) run[i] = m_cyc;
          if ((m_cyc % TD == TD - 1) &&
              nticks(run[i], m_cyc) == ST) begin
            m_db[i] = p2[i];
            if (p2[i]) m_rise[i] = 1'b1;
            else       m_fall[i] = 1'b1;
            run[i] = -1;
          end
        end
      end
      p2 = p1;
      p1 = bus.raw_input;
      m_cyc++;
    end
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  int n_tick;
  int n_act;
  int n_fall;
  int n_rise2;

  // One clock, then compare every output with the model.
  task automatic step(int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.tick === 1'b1) n_tick++;
      if (bus.any_change === 1'b1) n_act++;
      if (bus.fall[2] === 1'b1) n_fall++;
      if (bus.rise[2] === 1'b1) n_rise2++;
      chk("tick", 32'(bus.tick),
          32'(m_cyc % TD == TD - 1));
      chk("db", 32'(bus.db), 32'(m_db));
      chk("rise", 32'(bus.rise), 32'(m_rise));
      chk("fall", 32'(bus.fall), 32'(m_fall));
      chk("any", 32'(bus.any_change),
          32'(|(m_rise | m_fall)));
    end
  endtask

  // Leaves the bench at the negedge of cycle 0.
  task automatic do_reset(logic [CH-1:0] raw);
    rst = 1'b1;
    bus.raw_input = raw;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_db", 32'(bus.db), 32'h0);
    chk("rst_rise", 32'(bus.rise), 32'h0);
    chk("rst_fall", 32'(bus.fall), 32'h0);
    chk("rst_tick", 32'(bus.tick), 32'h0);
  endtask

  initial begin
    bus.raw_input = '0;
    n_tick = 0;
    n_act = 0;
    n_fall = 0;
    n_rise2 = 0;

    // 1: single channel rises after three ticks
    do_reset('0);
    bus.raw_input = 4'b0001;
    step(11);
    chk("s1_db11", 32'(bus.db), 32'h0);
    step(1);
    chk("s1_db12", 32'(bus.db), 32'h1);
    chk("s1_rise12", 32'(bus.rise), 32'h1);
    step(1);
    chk("s1_rise13", 32'(bus.rise), 32'h0);
    chk("s1_db13", 32'(bus.db), 32'h1);

    // 2: bounce restarts the count
    do_reset('0);
    bus.raw_input = 4'b0010;
    step(6);
    bus.raw_input = 4'b0000;
    step(4);
    bus.raw_input = 4'b0010;
    step(13);
    chk("s2_db23", 32'(bus.db), 32'h0);
    step(1);
    chk("s2_db24", 32'(bus.db), 32'h2);
    chk("s2_rise24", 32'(bus.rise), 32'h2);

    // 3: falling edge gives one fall pulse
    do_reset('0);
    bus.raw_input = 4'b0100;
    step(13);
    chk("s3_db_hi", 32'(bus.db), 32'h4);
    bus.raw_input = 4'b0000;
    n_fall = 0;
    n_rise2 = 0;
    step(2 + ST * TD + 4);
    chk("s3_db_lo", 32'(bus.db), 32'h0);
    chk("s3_nfall", 32'(n_fall), 32'd1);
    chk("s3_nrise", 32'(n_rise2), 32'd0);

    // 4: all channels flip together
    do_reset('0);
    bus.raw_input = 4'hF;
    n_act = 0;
    step(12);
    chk("s4_db", 32'(bus.db), 32'hF);
    chk("s4_rise", 32'(bus.rise), 32'hF);
    chk("s4_any", 32'(bus.any_change), 32'h1);
    step(1);
    chk("s4_any_off", 32'(bus.any_change), 32'h0);
    chk("s4_nact", 32'(n_act), 32'd1);

    // 5: reset mid-count discards progress
    do_reset('0);
    bus.raw_input = 4'b0001;
    step(8);
    rst = 1'b1;
    step(1);
    chk("s5_db_rst", 32'(bus.db), 32'h0);
    chk("s5_tick_rst", 32'(bus.tick), 32'h0);
    rst = 1'b0;
    step(11);
    chk("s5_db11", 32'(bus.db), 32'h0);
    step(1);
    chk("s5_db12", 32'(bus.db), 32'h1);
    chk("s5_rise12", 32'(bus.rise), 32'h1);

    // 6: idle inputs, only the tick runs
    do_reset('0);
    n_tick = 0;
    n_act = 0;
    step(1000);
    chk("s6_ntick", 32'(n_tick), 32'd250);
    chk("s6_nact", 32'(n_act), 32'd0);
    chk("s6_db", 32'(bus.db), 32'h0);

    // Random bouncing on all channels, one reset midway
    do_reset('0);
    for (int r = 0; r < 300; r++) begin
      bus.raw_input = CH'($urandom);
      step($urandom_range(1, 20));
      if (r == 150) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
